risc8_dmem_arb: RTL

- Arbiter for the SoC's single-port data RAM / IO bus, shared between two requesters: the risc8 core (port A) and a secondary master such as a DMA engine or debug loader (port B).
- Grants one access per cycle and drives the RAM/IO address, read and write strobes.
- Returns read data to the owning port after the RAM's fixed one-cycle registered latency.
- Port A has priority, with starvation protection and an atomic-lock mode for port B.

---
 rtl/risc8_dmem_arb_pkg.sv | 24 ++
 rtl/risc8_dmem_arb_if.sv | 47 ++++
 rtl/risc8_dmem_arb_grant.sv | 36 +++
 rtl/risc8_dmem_arb.sv | 131 +++++++++++++
 4 files changed

// File: rtl/risc8_dmem_arb_pkg.sv
// Shared bus definitions for the risc8 data-memory arbiter.
// Optional build macro: RISC8_DMEM_ARB_RR_EN (round-robin conflict resolution).
`ifndef RISC8_BUS_DEFS_VH
`define RISC8_BUS_DEFS_VH
`define RISC8_AW 16
`define RISC8_DW 8
`endif

package risc8_dmem_arb_pkg;
  localparam int RISC8_AW = `RISC8_AW;
  localparam int RISC8_DW = `RISC8_DW;

  // Upper bound of the IO window; addresses below this go to IO decode.
  localparam logic [RISC8_AW-1:0] IO_LIMIT = 16'h0060;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  function automatic logic is_io_addr(input logic [RISC8_AW-1:0] addr);
    return addr < IO_LIMIT;
  endfunction
endpackage

// File: rtl/risc8_dmem_arb_if.sv
// Requester / memory bus bundle for the risc8 data-memory arbiter.
// slave: arbiter view. master: requesters + RAM/IO view.
interface risc8_dmem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_lock;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic          mem_ren;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    input  mem_rdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_addr, mem_wen, mem_ren, mem_wdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    output mem_rdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_addr, mem_wen, mem_ren, mem_wdata
  );
endinterface

// File: rtl/risc8_dmem_arb_grant.sv
// Pure combinational grant resolver for the data-memory arbiter.
// Macro RISC8_DMEM_ARB_RR_EN swaps the starvation flag for a last-owner bit.
module risc8_dmem_arb_grant
  import risc8_dmem_arb_pkg::*;
(
  input  logic       a_req_i,
  input  logic       b_req_i,
  input  logic       lock_held_i,
`ifdef RISC8_DMEM_ARB_RR_EN
  input  owner_e     last_owner_i,
`else
  input  logic       starve_i,
`endif
  output logic [1:0] gnt_o        // [0] = port A, [1] = port B
);

  // Lock beats everything; lock with B idle leaves the bus idle on purpose.
  always_comb begin
    gnt_o = 2'b00;
    if (lock_held_i) begin
      gnt_o[1] = b_req_i;
`ifdef RISC8_DMEM_ARB_RR_EN
    end else if (a_req_i && b_req_i) begin
      gnt_o = (last_owner_i == OWNER_B) ? 2'b01 : 2'b10;
`else
    end else if (starve_i && b_req_i) begin
      gnt_o = 2'b10;
`endif
    end else if (a_req_i) begin
      gnt_o = 2'b01;
    end else if (b_req_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/risc8_dmem_arb.sv
// Two-port arbiter for the single-port data RAM / IO bus.
// Port A (core) has priority; port B gets starvation relief and an atomic lock.
// Macro RISC8_DMEM_ARB_RR_EN: round-robin conflicts instead of priority+starvation.
module risc8_dmem_arb
  import risc8_dmem_arb_pkg::*;
#(
  parameter int AW       = RISC8_AW,
  parameter int DW       = RISC8_DW,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  risc8_dmem_arb_if.slave    bus
);

  logic [1:0]    gnt;
  logic          gnt_any;
  logic          gnt_we;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;

  logic          lock_held_q, lock_held_d;
  logic          rd_pend_q, rd_pend_d;
  owner_e        rd_owner_q, rd_owner_d;

`ifdef RISC8_DMEM_ARB_RR_EN
  owner_e        last_owner_q, last_owner_d;

  risc8_dmem_arb_grant u_grant (
    .a_req_i      (bus.a_req),
    .b_req_i      (bus.b_req),
    .lock_held_i  (lock_held_q),
    .last_owner_i (last_owner_q),
    .gnt_o        (gnt)
  );

  // Remember who was granted last so the next conflict goes the other way.
  always_comb begin
    last_owner_d = last_owner_q;
    if (gnt_any) last_owner_d = gnt[1] ? OWNER_B : OWNER_A;
  end

  // Reset to B so that A wins the first conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_owner_q <= OWNER_B;
    else        last_owner_q <= last_owner_d;
  end
`else
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic          starve;

  assign starve = (starve_cnt_q == MAX_WAIT_C);

  risc8_dmem_arb_grant u_grant (
    .a_req_i     (bus.a_req),
    .b_req_i     (bus.b_req),
    .lock_held_i (lock_held_q),
    .starve_i    (starve),
    .gnt_o       (gnt)
  );

  // Count consecutive denied B cycles, saturating at MAX_WAIT.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt[1] || !bus.b_req)    starve_cnt_d = 4'd0;
    else if (!starve)            starve_cnt_d = starve_cnt_q + 4'd1;
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt_q <= 4'd0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`endif

  assign gnt_any   = |gnt;
  assign gnt_we    = gnt[1] ? bus.b_we : bus.a_we;
  assign bus.a_gnt = gnt[0];
  assign bus.b_gnt = gnt[1];

  // Route the granted port onto the memory bus; idle bus is all zeros.
  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (gnt[0]) begin
      mem_addr_d  = bus.a_addr;
      mem_wdata_d = bus.a_wdata;
    end else if (gnt[1]) begin
      mem_addr_d  = bus.b_addr;
      mem_wdata_d = bus.b_wdata;
    end
  end

  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  assign bus.mem_wen   = gnt_any & gnt_we;
  assign bus.mem_ren   = gnt_any & ~gnt_we;

  // Lock tracking and read-return bookkeeping.
  always_comb begin
    lock_held_d = lock_held_q;
    if (!bus.b_lock)  lock_held_d = 1'b0;
    else if (gnt[1])  lock_held_d = 1'b1;

    rd_pend_d  = gnt_any & ~gnt_we;
    rd_owner_d = rd_owner_q;
    if (rd_pend_d) rd_owner_d = gnt[1] ? OWNER_B : OWNER_A;
  end

  // Lock and pending-read registers; reset drops any in-flight read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_held_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= OWNER_A;
    end else begin
      lock_held_q <= lock_held_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  // RAM data is valid the cycle after the read strobe; steer it to the owner.
  assign bus.a_rvalid = rd_pend_q & (rd_owner_q == OWNER_A);
  assign bus.b_rvalid = rd_pend_q & (rd_owner_q == OWNER_B);
  assign bus.a_rdata  = bus.a_rvalid ? bus.mem_rdata : '0;
  assign bus.b_rdata  = bus.b_rvalid ? bus.mem_rdata : '0;

endmodule
